// File: rtl/audipus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : audipus_pkg
//  Description : Shared types and constants for the SRAM arbiter: FSM state
//                encoding and requester identifiers.
//  Revision    : 1.0 - initial release
// ============================================================================
package audipus_pkg;

    // Arbiter FSM states, 2-bit encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    // Requester identifiers, also driven on grant_id
    localparam logic [1:0] ID_AW   = 2'd0;
    localparam logic [1:0] ID_AR   = 2'd1;
    localparam logic [1:0] ID_CPU  = 2'd2;
    localparam logic [1:0] ID_NONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/sram_arb_priority.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_priority
//  Description : Combinational winner select. Fixed order aw > ar > cpu, with
//                the CPU promoted once it has lost CPU_MAX_WAIT audio grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_priority
    import audipus_pkg::*;
#(
    parameter int CPU_MAX_WAIT = 4
) (
    input  logic       aw_req,
    input  logic       ar_req,
    input  logic       cpu_req,
    input  logic [2:0] starve_cnt,
    output logic [1:0] winner
);

    logic w_cpu_promoted;

    assign w_cpu_promoted = cpu_req && (int'(starve_cnt) >= CPU_MAX_WAIT);

    // Promoted CPU overrides audio; otherwise plain fixed priority
    always_comb begin
        winner = ID_NONE;
        if (w_cpu_promoted) begin
            winner = ID_CPU;
        end else if (aw_req) begin
            winner = ID_AW;
        end else if (ar_req) begin
            winner = ID_AR;
        end else if (cpu_req) begin
            winner = ID_CPU;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arbiter
//  Description : Serializes audio write, audio read and CPU byte requests onto
//                one SQI engine command channel, with anti-starvation for the
//                CPU and a response watchdog that recovers a stalled engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter
    import audipus_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int CPU_MAX_WAIT = 4,
    parameter int TIMEOUT      = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              aw_req,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [15:0]       aw_data,
    output logic              aw_done,
    input  logic              ar_req,
    input  logic [ADDR_W-1:0] ar_addr,
    output logic              ar_done,
    output logic [15:0]       ar_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic              cpu_done,
    output logic [7:0]        cpu_rdata,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic              cmd_we,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [15:0]       cmd_wdata,
    output logic              cmd_len2,
    input  logic              rsp_valid,
    input  logic [15:0]       rsp_rdata,
    output logic              busy,
    output logic              timeout_err,
    input  logic              err_clr,
    output logic [1:0]        grant_id
);

    // Watchdog counts 0..TIMEOUT-1 inside one state; the last value fires
    localparam int              WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic [1:0]        w_winner;
    logic              w_grant;
    logic              w_advance;
    logic              w_rsp_ok;
    logic              w_timeout;
    logic              w_finish;

    logic [1:0]        r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_wdata;
    logic              r_len2;
    logic              r_cmd_valid;
    logic              r_busy;
    logic [1:0]        r_grant_id;
    logic [WD_W-1:0]   r_wd_cnt;
    logic [2:0]        r_starve_cnt;
    logic              r_timeout_err;
    logic              r_aw_done;
    logic              r_ar_done;
    logic              r_cpu_done;
    logic [15:0]       r_ar_data;
    logic [7:0]        r_cpu_rdata;

    sram_arb_priority #(
        .CPU_MAX_WAIT (CPU_MAX_WAIT)
    ) u_priority (
        .aw_req     (aw_req),
        .ar_req     (ar_req),
        .cpu_req    (cpu_req),
        .starve_cnt (r_starve_cnt),
        .winner     (w_winner)
    );

    // Handshake and completion qualifiers; a real response or handshake in the
    // same cycle as the watchdog limit takes precedence over the timeout
    assign w_rsp_ok  = (r_state == WAIT) && rsp_valid;
    assign w_advance = ((r_state == ISSUE) && cmd_ready) || w_rsp_ok;
    assign w_timeout = (r_state != IDLE) && !w_advance && (r_wd_cnt == WD_LAST);
    assign w_finish  = w_rsp_ok || w_timeout;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and grant decode
    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_winner != ID_NONE) begin
                    w_grant      = 1'b1;
                    w_next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_ready) begin
                    w_next_state = WAIT;
                end else if (w_timeout) begin
                    w_next_state = IDLE;
                end
            end
            WAIT: begin
                if (w_finish) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Registered status outputs follow the next state so they align with it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cmd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_grant_id  <= ID_NONE;
        end else begin
            r_cmd_valid <= (w_next_state == ISSUE);
            r_busy      <= (w_next_state != IDLE);
            if (w_next_state == IDLE) begin
                r_grant_id <= ID_NONE;
            end else if (w_grant) begin
                r_grant_id <= w_winner;
            end
        end
    end

    // Payload latch at grant, already mapped to engine command format
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= ID_NONE;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_len2  <= 1'b0;
        end else if (w_grant) begin
            r_owner <= w_winner;
            case (w_winner)
                ID_AW: begin
                    r_we    <= 1'b1;
                    r_addr  <= aw_addr;
                    r_wdata <= aw_data;
                    r_len2  <= 1'b1;
                end
                ID_AR: begin
                    r_we    <= 1'b0;
                    r_addr  <= ar_addr;
                    r_wdata <= '0;
                    r_len2  <= 1'b1;
                end
                default: begin
                    r_we    <= cpu_we;
                    r_addr  <= cpu_addr;
                    r_wdata <= {8'h00, cpu_wdata};
                    r_len2  <= 1'b0;
                end
            endcase
        end
    end

    // Watchdog: restarts on every state change, counts while a transfer is open
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= '0;
        end else if (w_next_state != r_state) begin
            r_wd_cnt <= '0;
        end else if (r_state != IDLE) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Starvation counter: audio wins while the CPU waits push it up (saturating)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve_cnt <= 3'd0;
        end else if (r_state == IDLE) begin
            if (!cpu_req || (w_winner == ID_CPU)) begin
                r_starve_cnt <= 3'd0;
            end else if (w_grant && (r_starve_cnt != 3'd7)) begin
                r_starve_cnt <= r_starve_cnt + 3'd1;
            end
        end
    end

    // Completion pulses and read data; a timed-out read returns zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aw_done   <= 1'b0;
            r_ar_done   <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_ar_data   <= '0;
            r_cpu_rdata <= '0;
        end else begin
            r_aw_done  <= w_finish && (r_owner == ID_AW);
            r_ar_done  <= w_finish && (r_owner == ID_AR);
            r_cpu_done <= w_finish && (r_owner == ID_CPU);
            if (w_finish && (r_owner == ID_AR)) begin
                r_ar_data <= w_rsp_ok ? rsp_rdata : 16'h0000;
            end
            if (w_finish && (r_owner == ID_CPU) && !r_we) begin
                r_cpu_rdata <= w_rsp_ok ? rsp_rdata[7:0] : 8'h00;
            end
        end
    end

    // Sticky timeout flag; a new timeout beats a simultaneous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end else if (err_clr) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign cmd_valid   = r_cmd_valid;
    assign cmd_we      = r_we;
    assign cmd_addr    = r_addr;
    assign cmd_wdata   = r_wdata;
    assign cmd_len2    = r_len2;
    assign busy        = r_busy;
    assign grant_id    = r_grant_id;
    assign timeout_err = r_timeout_err;
    assign aw_done     = r_aw_done;
    assign ar_done     = r_ar_done;
    assign cpu_done    = r_cpu_done;
    assign ar_data     = r_ar_data;
    assign cpu_rdata   = r_cpu_rdata;

endmodule
`default_nettype wire
